// File: rtl/force_release_ctrl.sv
// Command-driven per-bit force/release controller: drives the force mask/value
// pair and the overridden data vector, with timed PULSE forces.
module force_release_ctrl #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic             cmd_val,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] force_mask,
  output logic [WIDTH-1:0] force_val,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;
  typedef enum logic [1:0] {
    OP_FORCE       = 2'b00,
    OP_RELEASE     = 2'b01,
    OP_PULSE       = 2'b10,
    OP_RELEASE_ALL = 2'b11
  } op_t;

  localparam int unsigned WIDTH_U = WIDTH;

  state_t           state, state_next;
  op_t              op_q;
  logic [IDX_W-1:0] idx_q;
  logic             val_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] val_r;
  logic             done_q;
  logic             err_q;

  logic             accept;
  logic             idx_bad;
  logic             hold_last;
  logic [WIDTH-1:0] sel;
  logic [CNT_W-1:0] cnt_init;

  // One-hot select keeps the per-bit update free of out-of-range indexing;
  // an index beyond WIDTH shifts the bit out and is rejected by idx_bad anyway.
  assign sel       = WIDTH'(1) << idx_q;
  assign idx_bad   = (op_q != OP_RELEASE_ALL) && (32'(idx_q) >= WIDTH_U);
  assign cnt_init  = (len_q == '0) ? CNT_W'(1) : len_q;
  assign hold_last = (cnt <= CNT_W'(1));
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = APPLY;
      APPLY:   state_next = (op_q == OP_PULSE && !idx_bad) ? HOLD : IDLE;
      HOLD:    if (hold_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == IDLE) && !rst;
    busy       = (state != IDLE);
    done       = done_q;
    err        = err_q;
    force_mask = mask_q;
    force_val  = val_r;
    o_data     = (i_data & ~mask_q) | (val_r & mask_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_FORCE;
      idx_q  <= '0;
      val_q  <= 1'b0;
      len_q  <= '0;
      cnt    <= '0;
      mask_q <= '0;
      val_r  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op_t'(cmd_op);
            idx_q <= cmd_idx;
            val_q <= cmd_val;
            len_q <= cmd_len;
          end
        end
        APPLY: begin
          if (idx_bad) begin
            err_q <= 1'b1;
          end else begin
            case (op_q)
              OP_FORCE: begin
                mask_q <= mask_q | sel;
                val_r  <= val_q ? (val_r | sel) : (val_r & ~sel);
                done_q <= 1'b1;
              end
              OP_RELEASE: begin
                mask_q <= mask_q & ~sel;
                done_q <= 1'b1;
              end
              OP_PULSE: begin
                mask_q <= mask_q | sel;
                val_r  <= val_q ? (val_r | sel) : (val_r & ~sel);
                cnt    <= cnt_init;
              end
              OP_RELEASE_ALL: begin
                mask_q <= '0;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        HOLD: begin
          cnt <= cnt - CNT_W'(1);
          if (hold_last) begin
            mask_q <= mask_q & ~sel;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_force_release_ctrl.sv
// Scoreboard bench for force_release_ctrl: directed scenarios plus random
// commands checked against a bit-level reference model.
module tb_force_release_ctrl;

  localparam int W  = 8;
  localparam int IW = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [IW-1:0] cmd_idx;
  logic          cmd_val;
  logic [CW-1:0] cmd_len;
  logic [W-1:0]  i_data;
  logic [W-1:0]  o_data;
  logic [W-1:0]  force_mask;
  logic [W-1:0]  force_val;
  logic          busy;
  logic          done;
  logic          err;

  logic          cmd_valid_6;
  logic          cmd_ready_6;
  logic [1:0]    cmd_op_6;
  logic [2:0]    cmd_idx_6;
  logic          cmd_val_6;
  logic [7:0]    cmd_len_6;
  logic [5:0]    i_data_6;
  logic [5:0]    o_data_6;
  logic [5:0]    force_mask_6;
  logic [5:0]    force_val_6;
  logic          busy_6;
  logic          done_6;
  logic          err_6;

  force_release_ctrl #(.WIDTH(W), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_val(cmd_val), .cmd_len(cmd_len),
    .i_data(i_data), .o_data(o_data), .force_mask(force_mask),
    .force_val(force_val), .busy(busy), .done(done), .err(err)
  );

  force_release_ctrl #(.WIDTH(6), .IDX_W(3), .CNT_W(8)) dut6 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_6), .cmd_ready(cmd_ready_6),
    .cmd_op(cmd_op_6), .cmd_idx(cmd_idx_6), .cmd_val(cmd_val_6), .cmd_len(cmd_len_6),
    .i_data(i_data_6), .o_data(o_data_6), .force_mask(force_mask_6),
    .force_val(force_val_6), .busy(busy_6), .done(done_6), .err(err_6)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] mask;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_mask;
  logic [7:0] m_val;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         rand_data = 1'b0;
  logic [7:0] fixed_data = 8'hFF;
  time        hs_time;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source data changes away from the sampling edge.
  initial begin
    i_data = 8'hFF;
    forever begin
      @(posedge clk);
      #2;
      i_data = rand_data ? 8'($urandom) : fixed_data;
    end
  end

  // Monitor: output mux, handshake consistency and completion scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("o_data_mux", o_data, (i_data & ~force_mask) | (force_val & force_mask));
      check("ready_is_idle", cmd_ready, !busy);
      if (done || err) begin
        check("done_err_excl", done & err, 0);
        if (sb.size() == 0) begin
          check("unexpected_resp", {done, err}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_kind_err", err, e.is_err);
          check("resp_mask", force_mask, e.mask);
          check("resp_val", force_val, e.val);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int idx, input logic v, input int len);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 0, 1);
    cmd_op    = op;
    cmd_idx   = IW'(idx);
    cmd_val   = v;
    cmd_len   = CW'(len);
    cmd_valid = 1'b1;
    case (op)
      2'b00: begin m_mask[idx] = 1'b1; m_val[idx] = v; end
      2'b01: m_mask[idx] = 1'b0;
      2'b10: begin m_val[idx] = v; m_mask[idx] = 1'b0; end
      default: m_mask = '0;
    endcase
    e.is_err = 1'b0;
    e.mask   = m_mask;
    e.val    = m_val;
    sb.push_back(e);
    @(posedge clk);
    hs_time = $time;
    #1 cmd_valid = 1'b0;
  endtask

  // PULSE with cycle accounting up to its done pulse.
  task automatic pulse(input int idx, input logic v, input int len, output int od_c);
    int n, prev, busy_c, mask_c, ready_c, guard;
    prev = int'(m_mask[idx]);
    n = (len == 0) ? 1 : len;
    busy_c = 0; mask_c = 0; ready_c = 0; od_c = 0; guard = 0;
    issue(2'b10, idx, v, len);
    forever begin
      @(negedge clk);
      if (done || guard > 600) break;
      busy_c  += int'(busy);
      mask_c  += int'(force_mask[idx]);
      ready_c += int'(cmd_ready);
      od_c    += int'(o_data[idx] == v);
      guard++;
    end
    check("pulse_done_seen", int'(guard <= 600), 1);
    check("pulse_busy_cycles", busy_c, n + 1);
    check("pulse_forced_cycles", mask_c, n + prev);
    check("pulse_ready_low", ready_c, 0);
  endtask

  task automatic issue6(input logic [1:0] op, input int idx, input logic v,
                        input int exp_err, input int exp_done, input logic [5:0] exp_mask);
    int guard, err_c, done_c;
    guard = 0; err_c = 0; done_c = 0;
    @(negedge clk);
    while (!cmd_ready_6 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    cmd_op_6 = op; cmd_idx_6 = 3'(idx); cmd_val_6 = v; cmd_len_6 = 8'd1;
    cmd_valid_6 = 1'b1;
    @(posedge clk);
    #1 cmd_valid_6 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      err_c  += int'(err_6);
      done_c += int'(done_6);
    end
    check("w6_err_count", err_c, exp_err);
    check("w6_done_count", done_c, exp_done);
    check("w6_mask", force_mask_6, exp_mask);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int od, guard;
    logic [1:0] op, prev_op;
    time prev_hs;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_val = 1'b0; cmd_len = '0;
    cmd_valid_6 = 1'b0; cmd_op_6 = '0; cmd_idx_6 = '0; cmd_val_6 = 1'b0; cmd_len_6 = '0;
    i_data_6 = '0;
    m_mask = '0; m_val = '0;
    repeat (3) @(negedge clk);
    check("rst_mask", force_mask, 0);
    check("rst_val", force_val, 0);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_odata", o_data, 8'hFF);
    rst = 1'b0;
    #1 check("ready_after_rst", cmd_ready, 1);

    // FORCE idx 6 to 0 over all-ones data
    issue(2'b00, 6, 1'b0, 0);
    @(negedge clk);
    check("force6_pre_apply", o_data, 8'hFF);
    @(negedge clk);
    check("force6_odata", o_data, 8'hBF);
    check("force6_mask", force_mask, 8'h40);
    check("force6_done", done, 1);
    @(negedge clk);
    check("force6_done_1cyc", done, 0);

    // FORCE then RELEASE idx 2 over zero data
    fixed_data = 8'h00;
    issue(2'b00, 2, 1'b1, 0);
    repeat (2) @(negedge clk);
    check("force2_odata", o_data, 8'h04);
    issue(2'b01, 2, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("release2_odata", o_data, 8'h00);
    check("release2_val_kept", force_val[2], 1);
    issue(2'b01, 5, 1'b0, 0);   // unforced bit: no-op but done
    repeat (2) @(negedge clk);
    check("release_noop_mask", force_mask, 8'h40);

    // timed PULSE, including len 0 and overwrite of a forced bit
    pulse(0, 1'b1, 5, od);
    check("pulse5_odata_cycles", od, 5);
    pulse(0, 1'b1, 0, od);
    check("pulse0_odata_cycles", od, 1);
    pulse(6, 1'b1, 3, od);
    check("pulse_overwrite_mask", force_mask, 8'h00);

    // multi-bit force then RELEASE_ALL
    issue(2'b00, 1, 1'b1, 0);
    issue(2'b00, 3, 1'b1, 0);
    issue(2'b00, 7, 1'b1, 0);
    repeat (2) @(negedge clk);
    check("multi_mask", force_mask, 8'h8A);
    pulse(3, 1'b0, 2, od);
    check("pulse_keeps_others", force_mask, 8'h82);
    issue(2'b11, 0, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("release_all_mask", force_mask, 8'h00);
    rand_data = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("track_idata", o_data, i_data);
    end

    // reset in the middle of a long PULSE
    issue(2'b10, 4, 1'b1, 20);
    repeat (6) @(negedge clk);
    check("hold_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_mask", force_mask, 0);
    check("midrst_odata", o_data, i_data);
    check("midrst_ready", cmd_ready, 0);
    sb.delete();
    m_mask = '0; m_val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_ready_after", cmd_ready, 1);
    issue(2'b00, 5, 1'b1, 0);
    repeat (2) @(negedge clk);
    check("midrst_force_after", force_mask, 8'h20);

    // random traffic; non-PULSE commands must sustain one per two cycles
    prev_op = 2'b00;
    prev_hs = 0;
    for (int k = 0; k < 150; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if (op == 2'b10) begin
        pulse(int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 12)), od);
        prev_hs = 0;
      end else begin
        issue(op, int'($urandom_range(0, 7)), 1'($urandom), 0);
        if (prev_hs != 0 && prev_op != 2'b10) check("throughput", 32'(hs_time - prev_hs), 20);
        prev_hs = hs_time;
      end
      prev_op = op;
    end

    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    rand_data = 1'b0;

    // narrow instance: out-of-range index is rejected
    issue6(2'b00, 7, 1'b1, 1, 0, 6'h00);
    issue6(2'b00, 5, 1'b1, 0, 1, 6'h20);
    issue6(2'b10, 6, 1'b1, 1, 0, 6'h20);
    issue6(2'b11, 7, 1'b0, 0, 1, 6'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
